// File: rtl/spi_master_reg_ctrl.sv
// SPI master (mode 0, MSB first) for register write/read frames to the
// slave's four 8-bit configuration registers. One 16-bit frame per request:
// 8 command bits followed by 8 data bits, no dummy cycles.
module spi_master_reg_ctrl #(
  parameter int CLK_DIV = 4,
  parameter int DIV_W   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [1:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       spi_sck,
  output logic       spi_csn,
  output logic       spi_sdo,
  input  logic       spi_sdi
);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD, GAP} state_t;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  // Command byte understood by the slave for each (write, addr) pair
  function automatic logic [7:0] cmd_byte(input logic write, input logic [1:0] addr);
    case ({write, addr})
      3'b100:  cmd_byte = 8'h01;
      3'b101:  cmd_byte = 8'h11;
      3'b110:  cmd_byte = 8'h20;
      3'b111:  cmd_byte = 8'h30;
      3'b000:  cmd_byte = 8'h05;
      3'b001:  cmd_byte = 8'h07;
      3'b010:  cmd_byte = 8'h21;
      default: cmd_byte = 8'h31;
    endcase
  endfunction

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic [3:0]       bit_cnt;
  logic [15:0]      tx_sr;
  logic [7:0]       rx_sr;
  logic             is_wr;
  logic [7:0]       cmd_sel;
  logic             accept;
  logic             div_end;
  logic             rise_stb;
  logic             fall_stb;

  assign cmd_sel  = cmd_byte(req_write, req_addr);
  assign accept   = (state == IDLE) && req_ready && req_valid;
  assign div_end  = (div_cnt == DIV_LAST);
  assign rise_stb = (state == SHIFT) && div_end && !spi_sck;
  assign fall_stb = (state == SHIFT) && div_end && spi_sck;

  // Frame data: latch the request at acceptance, shift out on falling sck,
  // collect sdi on rising sck during the data byte of a read
  always_ff @(posedge clk) begin
    if (accept) begin
      tx_sr <= {cmd_sel, req_write ? req_wdata : 8'h00};
      is_wr <= req_write;
    end else if (fall_stb) begin
      tx_sr <= {tx_sr[14:0], 1'b0};
    end
    if (rise_stb && !is_wr && bit_cnt[3]) begin
      rx_sr <= {rx_sr[6:0], spi_sdi};
    end
  end

  // Frame sequencer: IDLE -> SHIFT (16 bits) -> HOLD -> GAP -> IDLE, all pins registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h00;
      spi_sck   <= 1'b0;
      spi_csn   <= 1'b1;
      spi_sdo   <= 1'b0;
      div_cnt   <= '0;
      bit_cnt   <= 4'd0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            req_ready <= 1'b0;
            spi_csn   <= 1'b0;
            spi_sdo   <= cmd_sel[7];
            div_cnt   <= '0;
            bit_cnt   <= 4'd0;
            state     <= SHIFT;
          end else begin
            req_ready <= 1'b1;
          end
        end
        SHIFT: begin
          if (!div_end) begin
            div_cnt <= div_cnt + DIV_W'(1);
          end else begin
            div_cnt <= '0;
            if (!spi_sck) begin
              spi_sck <= 1'b1;
            end else begin
              spi_sck <= 1'b0;
              if (bit_cnt == 4'd15) begin
                spi_sdo <= 1'b0;
                state   <= HOLD;
              end else begin
                spi_sdo <= tx_sr[14];
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end
        end
        HOLD: begin
          if (!div_end) begin
            div_cnt <= div_cnt + DIV_W'(1);
          end else begin
            div_cnt   <= '0;
            spi_csn   <= 1'b1;
            rsp_valid <= 1'b1;
            if (!is_wr) rsp_rdata <= rx_sr;
            state     <= GAP;
          end
        end
        GAP: begin
          if (!div_end) begin
            div_cnt <= div_cnt + DIV_W'(1);
          end else begin
            div_cnt   <= '0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_reg_ctrl.sv
// Bench for spi_master_reg_ctrl: two instances (CLK_DIV=2 and CLK_DIV=1)
// share one behavioural SPI slave holding the four configuration registers.
module tb_spi_master_reg_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       req_valid = 1'b0;
  logic       req_write = 1'b0;
  logic [1:0] req_addr  = 2'd0;
  logic [7:0] req_wdata = 8'h00;
  logic       sel       = 1'b0;
  logic       sdi       = 1'b0;

  logic       rdy_a, rv_a, sck_a, csn_a, sdo_a;
  logic [7:0] rd_a;
  logic       rdy_b, rv_b, sck_b, csn_b, sdo_b;
  logic [7:0] rd_b;

  wire vld_a = req_valid && !sel;
  wire vld_b = req_valid && sel;

  spi_master_reg_ctrl #(.CLK_DIV(2), .DIV_W(8)) u_dut_a (
    .clk(clk), .rst(rst), .req_valid(vld_a), .req_ready(rdy_a), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rv_a), .rsp_rdata(rd_a),
    .spi_sck(sck_a), .spi_csn(csn_a), .spi_sdo(sdo_a), .spi_sdi(sdi)
  );

  spi_master_reg_ctrl #(.CLK_DIV(1), .DIV_W(8)) u_dut_b (
    .clk(clk), .rst(rst), .req_valid(vld_b), .req_ready(rdy_b), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rv_b), .rsp_rdata(rd_b),
    .spi_sck(sck_b), .spi_csn(csn_b), .spi_sdo(sdo_b), .spi_sdi(sdi)
  );

  wire       m_ready = sel ? rdy_b : rdy_a;
  wire       m_rv    = sel ? rv_b  : rv_a;
  wire [7:0] m_rd    = sel ? rd_b  : rd_a;
  wire       m_sck   = sel ? sck_b : sck_a;
  wire       m_csn   = sel ? csn_b : csn_a;
  wire       m_sdo   = sel ? sdo_b : sdo_a;

  // Command table indexed by {write, addr}
  localparam logic [7:0] CMD_TAB [8] = '{8'h05, 8'h07, 8'h21, 8'h31, 8'h01, 8'h11, 8'h20, 8'h30};

  // Slave command decode: {hit, write, addr}
  function automatic logic [3:0] sl_dec(input logic [7:0] c);
    sl_dec = 4'b0000;
    for (int i = 0; i < 8; i++) if (CMD_TAB[i] == c) sl_dec = {1'b1, 3'(i)};
  endfunction

  // Behavioural slave, observed mid-cycle
  logic        sck_q = 1'b0;
  logic        csn_q = 1'b1;
  logic [15:0] sl_sh = 16'h0000;
  int          sl_n  = 0;
  logic [7:0]  sl_cmd = 8'h00;
  logic [7:0]  sl_regs [4] = '{default: 8'h00};
  wire  [3:0]  dc_end  = sl_dec(sl_sh[15:8]);
  wire  [3:0]  dc_fall = sl_dec((sl_n == 8) ? sl_sh[7:0] : sl_cmd);

  always @(negedge clk) begin
    sck_q <= m_sck;
    csn_q <= m_csn;
    if (m_csn) begin
      if (!csn_q && sl_n == 16 && dc_end[3] && dc_end[2]) sl_regs[dc_end[1:0]] <= sl_sh[7:0];
      sl_n <= 0;
      sdi  <= 1'b0;
    end else if (m_sck && !sck_q) begin
      sl_sh <= {sl_sh[14:0], m_sdo};
      sl_n  <= sl_n + 1;
    end else if (!m_sck && sck_q) begin
      if (sl_n == 8) sl_cmd <= sl_sh[7:0];
      if (sl_n >= 8 && sl_n < 16 && dc_fall[3] && !dc_fall[2]) sdi <= sl_regs[dc_fall[1:0]][15 - sl_n];
      else sdi <= 1'b0;
    end
  end

  // Reference model
  logic [7:0] model_regs [4] = '{default: 8'h00};
  logic [7:0] last_rd [2] = '{default: 8'h00};

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic w, input logic [1:0] a, input logic [7:0] d);
    int cyc = 0;
    req_write = w; req_addr = a; req_wdata = d; req_valid = 1'b1;
    while (!m_ready && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("accept_wait", 32'(cyc < 200), 32'd1);
    @(negedge clk);
  endtask

  task automatic run_frame(input logic w, input logic [1:0] a, input logic [7:0] d, input bit junk);
    int dv = sel ? 1 : 2;
    int cyc = 0, low = 0, rises = 0, rsp_n = 0, rsp_at = -1, rise_at = -1, rdy_at = -1, bad = 0;
    logic [15:0] frame = 16'h0;
    logic [15:0] exp_frame = {CMD_TAB[{w, a}], w ? d : 8'h00};
    logic prev_sck = 1'b0, prev_csn = 1'b0;
    logic [7:0] rdata = 8'h00;
    while (cyc < 400) begin
      if (!m_csn) low++;
      if (m_sck && !prev_sck) begin frame = {frame[14:0], m_sdo}; rises++; end
      if (m_csn && m_sck) bad++;
      if (m_csn && !prev_csn && rise_at < 0) rise_at = cyc;
      if (m_rv) begin rsp_n++; rsp_at = cyc; rdata = m_rd; end
      if (junk) begin
        if (!m_csn && rises < 14) begin
          req_valid = 1'($urandom_range(0, 1)); req_write = 1'($urandom);
          req_addr = 2'($urandom); req_wdata = 8'($urandom);
        end else req_valid = 1'b0;
      end
      if (m_ready && rsp_n > 0) begin rdy_at = cyc; break; end
      prev_sck = m_sck; prev_csn = m_csn;
      @(negedge clk);
      cyc++;
    end
    chk("frame_done", 32'(rdy_at >= 0), 32'd1);
    chk("csn_low_cycles", 32'(low), 32'(33 * dv));
    chk("sck_rises", 32'(rises), 32'd16);
    chk("sdo_frame", 32'(frame), 32'(exp_frame));
    chk("rsp_pulses", 32'(rsp_n), 32'd1);
    chk("rsp_at_csn_rise", 32'(rsp_at), 32'(rise_at));
    chk("ready_after_rsp", 32'(rdy_at - rsp_at), 32'(dv));
    chk("csn_gap_min", 32'(rdy_at - rise_at + 1 >= dv), 32'd1);
    chk("sck_idle_low", 32'(bad), 32'd0);
    if (w) model_regs[a] = d;
    else last_rd[sel] = model_regs[a];
    chk(w ? "rdata_kept" : "rdata_read", 32'(rdata), 32'(last_rd[sel]));
  endtask

  task automatic txn(input logic w, input logic [1:0] a, input logic [7:0] d, input bit junk);
    issue(w, a, d);
    req_valid = 1'b0;
    req_write = 1'($urandom); req_addr = 2'($urandom); req_wdata = 8'($urandom);
    run_frame(w, a, d, junk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int rises;
    int rv_seen;
    logic psck;
    repeat (3) @(negedge clk);
    chk("rst_ready_a", 32'(rdy_a), 32'd0);
    chk("rst_csn_a", 32'(csn_a), 32'd1);
    chk("rst_sck_a", 32'(sck_a), 32'd0);
    chk("rst_sdo_a", 32'(sdo_a), 32'd0);
    chk("rst_rv_a", 32'(rv_a), 32'd0);
    chk("rst_rdata_a", 32'(rd_a), 32'd0);
    chk("rst_csn_b", 32'(csn_b), 32'd1);
    chk("rst_ready_b", 32'(rdy_b), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready_a", 32'(rdy_a), 32'd1);
    chk("post_rst_ready_b", 32'(rdy_b), 32'd1);

    sel = 1'b0;
    txn(1'b1, 2'd1, 8'h20, 1'b0);
    txn(1'b1, 2'd0, 8'hA5, 1'b1);
    txn(1'b0, 2'd0, 8'h00, 1'b1);

    txn(1'b1, 2'd0, 8'h01, 1'b1);
    txn(1'b1, 2'd1, 8'h32, 1'b1);
    txn(1'b1, 2'd2, 8'h34, 1'b1);
    txn(1'b1, 2'd3, 8'h12, 1'b1);
    for (int i = 0; i < 4; i++) txn(1'b0, 2'(i), 8'h00, 1'b1);
    chk("slave_en_qpi", 32'(sl_regs[0][0]), 32'd1);
    chk("slave_dummy", 32'(sl_regs[1]), 32'h32);
    chk("slave_wrap", 32'({sl_regs[3], sl_regs[2]}), 32'h1234);

    // Back-to-back writes with req_valid held and fields changed mid-frame
    issue(1'b1, 2'd2, 8'h5A);
    req_wdata = 8'hC3; req_addr = 2'd3;
    run_frame(1'b1, 2'd2, 8'h5A, 1'b0);
    issue(1'b1, 2'd3, 8'hC3);
    req_valid = 1'b0;
    run_frame(1'b1, 2'd3, 8'hC3, 1'b0);

    // Reset during bit 5 of a read
    issue(1'b0, 2'd1, 8'h00);
    req_valid = 1'b0;
    cyc = 0; rises = 0; psck = 1'b0;
    while (rises < 6 && cyc < 200) begin
      if (m_sck && !psck) rises++;
      psck = m_sck;
      if (rises < 6) begin @(negedge clk); cyc++; end
    end
    chk("rst_mid_reach", 32'(rises), 32'd6);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_csn", 32'(csn_a), 32'd1);
    chk("mid_rst_sck", 32'(sck_a), 32'd0);
    chk("mid_rst_sdo", 32'(sdo_a), 32'd0);
    chk("mid_rst_rv", 32'(rv_a), 32'd0);
    chk("mid_rst_rdata", 32'(rd_a), 32'd0);
    rst = 1'b0;
    last_rd[0] = 8'h00;
    last_rd[1] = 8'h00;
    rv_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (rv_a || !csn_a) rv_seen++;
    end
    chk("post_rst_quiet", 32'(rv_seen), 32'd0);
    txn(1'b0, 2'd2, 8'h00, 1'b0);

    // CLK_DIV=1 instance
    sel = 1'b1;
    txn(1'b1, 2'd3, 8'hFF, 1'b0);
    txn(1'b0, 2'd3, 8'h00, 1'b0);

    // Randomised mix across both instances
    for (int i = 0; i < 14; i++) begin
      sel = 1'($urandom);
      txn(1'($urandom), 2'($urandom), 8'($urandom), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
